// File: rtl/arm_mem_pkg.sv
// Shared constants for the ARM core data-memory responder:
// word width and the MMIO register addresses.
package arm_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] MMIO_LED_ADDR = 32'h8000_0000;
    localparam logic [WORD_W-1:0] MMIO_CNT_ADDR = 32'h8000_0004;

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO LED register and free-running cycle counter.
// Only instantiated when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
    import arm_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              led_we,
    input  logic [WORD_W-1:0] led_wdata,
    output logic [WORD_W-1:0] leds,
    output logic [WORD_W-1:0] cnt
);

    logic [WORD_W-1:0] leds_d, leds_q;
    logic [WORD_W-1:0] cnt_d, cnt_q;

    always_comb begin
        leds_d = led_we ? led_wdata : leds_q;
        cnt_d  = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q <= '0;
            cnt_q  <= '0;
        end else begin
            leds_q <= leds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign leds = leds_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-wait loads, posted stores via a one-entry
// write buffer with forwarding. Define DMEM_MMIO_EN for LED/counter MMIO.
module dmem_responder
    import arm_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] ALUResult,
    input  logic [WORD_W-1:0] WriteData,
    output logic [WORD_W-1:0] ReadData,
    output logic              Err,
    output logic [WORD_W-1:0] Leds
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] RAM_BYTES = WORD_W'(4 * DEPTH_WORDS);

    logic [WORD_W-1:0] ram_q [DEPTH_WORDS];

    logic              wb_vld_d, wb_vld_q;
    logic [IDX_W-1:0]  wb_idx_d, wb_idx_q;
    logic [WORD_W-1:0] wb_data_d, wb_data_q;
    logic              err_d, err_q;

    logic              in_ram;
    logic [IDX_W-1:0]  idx;
    logic              wb_hit;
    logic              st_bad;
    logic [WORD_W-1:0] ram_rd;

`ifdef DMEM_MMIO_EN
    logic              is_led;
    logic              is_cnt;
    logic [WORD_W-1:0] cnt;

    assign is_led = (ALUResult == MMIO_LED_ADDR);
    assign is_cnt = (ALUResult == MMIO_CNT_ADDR);

    dmem_mmio_regs u_mmio (
        .clk       (clk),
        .reset     (reset),
        .led_we    (MemWrite && is_led),
        .led_wdata (WriteData),
        .leds      (Leds),
        .cnt       (cnt)
    );
`else
    // Counter keeps running with no read path when MMIO is absent.
    logic [WORD_W-1:0] cnt_d, cnt_q;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign Leds = '0;
`endif

    always_comb begin
        in_ram = (ALUResult[1:0] == 2'b00) && (ALUResult < RAM_BYTES);
        idx    = ALUResult[IDX_W+1:2];
        wb_hit = wb_vld_q && (wb_idx_q == idx);
        ram_rd = wb_hit ? wb_data_q : ram_q[idx];
    end

    always_comb begin
        ReadData = '0;
        if (in_ram) ReadData = ram_rd;
`ifdef DMEM_MMIO_EN
        else if (is_led) ReadData = Leds;
        else if (is_cnt) ReadData = cnt;
`endif
    end

    always_comb begin
`ifdef DMEM_MMIO_EN
        st_bad = MemWrite && !in_ram && !is_led;
`else
        st_bad = MemWrite && !in_ram;
`endif
        wb_vld_d  = MemWrite && in_ram;
        wb_idx_d  = wb_vld_d ? idx : wb_idx_q;
        wb_data_d = wb_vld_d ? WriteData : wb_data_q;
        err_d     = err_q | st_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wb_vld_q <= wb_vld_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        wb_idx_q  <= wb_idx_d;
        wb_data_q <= wb_data_d;
    end

    // Retire happens in the same edge that may accept the next store.
    always_ff @(posedge clk) begin
        if (!reset && wb_vld_q) ram_q[wb_idx_q] <= wb_data_q;
    end

    assign Err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder, plus hand sequences
// for reset, error stickiness and MMIO behaviour.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Err;
    logic [31:0] Leds;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder #(.DEPTH_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Err       (Err),
        .Leds      (Leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset     = rst;
        MemWrite  = we;
        ALUResult = a;
        WriteData = d;
        #1;
    endtask

    logic [31:0] c0, c1;

    initial begin
        vecs[0]  = '{1'b1, 32'h10,  32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b0, 32'h10,  32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b1, 32'h20,  32'hAAAA_AAAA, 1'b0, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h20,  32'h5555_5555, 1'b1, 32'hAAAA_AAAA, 1'b0};
        vecs[5]  = '{1'b0, 32'h20,  32'h0,         1'b1, 32'h5555_5555, 1'b0};
        vecs[6]  = '{1'b0, 32'h20,  32'h0,         1'b1, 32'h5555_5555, 1'b0};
        vecs[7]  = '{1'b1, 32'h40,  32'h1111_1111, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h40,  32'h0,         1'b1, 32'h1111_1111, 1'b0};
        vecs[9]  = '{1'b0, 32'h100, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h11,  32'h0,         1'b1, 32'h0,         1'b0};

        reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        repeat (3) @(posedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("reset_err", {31'b0, Err}, 32'h0);
        check("reset_leds", Leds, 32'h0);

        for (int i = 0; i < 11; i++) begin
            drive(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, Err},
                  {31'b0, vecs[i].exp_err});
        end

        // misaligned and out-of-range stores are dropped, Err sticks
        drive(1'b0, 1'b1, 32'h13, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF);
        check("misal_err", {31'b0, Err}, 32'h1);
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        check("misal_nowrite", ReadData, 32'h1234_5678);
        drive(1'b0, 1'b0, 32'h100, 32'h0);
        check("oor_load", ReadData, 32'h0);
        repeat (3) drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("err_sticky", {31'b0, Err}, 32'h1);

        // pending store discarded by reset; stores during reset ignored
        drive(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 32'h13, 32'h0);
        drive(1'b1, 1'b1, 32'h40, 32'hBAD0_BAD0);
        drive(1'b0, 1'b0, 32'h40, 32'h0);
        check("rst_err", {31'b0, Err}, 32'h0);
        check("rst_leds", Leds, 32'h0);
        check("rst_discard", ReadData, 32'h1111_1111);
        drive(1'b0, 1'b0, 32'h40, 32'h0);
        check("rst_ram_kept", ReadData, 32'h1111_1111);
        drive(1'b0, 1'b0, 32'h20, 32'h0);
        check("rst_ram_20", ReadData, 32'h5555_5555);

`ifdef DMEM_MMIO_EN
        drive(1'b0, 1'b1, 32'h8000_0000, 32'h0000_00FF);
        drive(1'b0, 1'b0, 32'h8000_0000, 32'h0);
        check("mmio_leds", Leds, 32'hFF);
        check("mmio_led_rd", ReadData, 32'hFF);
        check("mmio_led_err", {31'b0, Err}, 32'h0);
        drive(1'b0, 1'b0, 32'h8000_0004, 32'h0);
        c0 = ReadData;
        repeat (5) drive(1'b0, 1'b0, 32'h8000_0004, 32'h0);
        c1 = ReadData;
        check("mmio_cnt_delta", c1 - c0, 32'd5);
        drive(1'b0, 1'b1, 32'h8000_0004, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("mmio_cnt_st_err", {31'b0, Err}, 32'h1);
`else
        c0 = '0; c1 = '0;
        drive(1'b0, 1'b1, 32'h8000_0000, 32'h0000_00FF);
        drive(1'b0, 1'b0, 32'h8000_0000, 32'h0);
        check("nommio_err", {31'b0, Err}, 32'h1);
        check("nommio_leds", Leds, 32'h0);
        check("nommio_rd", ReadData, 32'h0);
        drive(1'b0, 1'b0, 32'h8000_0004, 32'h0);
        check("nommio_cnt_rd", ReadData, 32'h0 | (c1 - c0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, RAM size in 32-bit words at byte addresses 0 .. 4*DEPTH_WORDS-1.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: MemWrite  input  1  write strobe from the core's memory stage.
REQ-005 Port: ALUResult  input  32  byte address from the core.
REQ-006 Port: WriteData  input  32  store data.
REQ-007 Port: ReadData  output  32  load data, combinational from ALUResult and current state.
REQ-008 Port: Err  output  1  sticky access-error flag.
REQ-009 Port: Leds  output  32  MMIO LED register contents.

Function
REQ-010 The block SHALL be the responder to the ARM core's data-memory interface, with zero-wait-state loads and posted stores.
REQ-011 An address SHALL be valid-RAM when ALUResult[1:0]==0 and ALUResult < 4*DEPTH_WORDS; the word index is ALUResult[31:2].
REQ-012 A store to valid-RAM SHALL be captured into a one-entry write buffer (valid, word index, data) on the edge where MemWrite=1.
REQ-013 A buffered entry SHALL retire into the RAM array on the next rising edge, in the same edge that accepts any new store (buffer occupancy never exceeds one).
REQ-014 A load SHALL return the buffer data when the buffer is valid and its index matches, else the RAM word (read-after-write forwarding, no stall).
REQ-015 Back-to-back stores to the same word SHALL leave the later data visible on the next cycle and in RAM after retirement.
REQ-016 A store with ALUResult[1:0]!=0 or to an unmapped address SHALL be dropped and SHALL set Err on that edge.
REQ-017 A load from an unmapped or misaligned address SHALL return 32'h0 and SHALL NOT set Err.
REQ-018 Err SHALL remain set until reset.
REQ-019 A 32-bit free-running cycle counter SHALL increment every cycle and wrap 32'hFFFF_FFFF -> 0.

Reset
REQ-020 On reset: write-buffer valid=0 (pending store discarded), Err=0, Leds=0, counter=0.
REQ-021 RAM contents SHALL NOT be altered by reset.
REQ-022 A store presented in the same cycle as reset=1 SHALL be ignored.

Configuration
REQ-023 Macro DMEM_MMIO_EN defined: address 32'h8000_0000 is LED register (R/W, write updates Leds next edge), 32'h8000_0004 is the cycle counter (read-only; store sets Err).
REQ-024 Macro DMEM_MMIO_EN undefined: both addresses are unmapped per REQ-016/017, Leds tied to 0; the cycle counter still exists internally but is unreadable.

Structure
REQ-025 Shared package arm_mem_pkg SHALL hold MMIO_LED_ADDR, MMIO_CNT_ADDR and the word-data width constant.
REQ-026 The LED register and cycle counter SHALL live in one sub-module dmem_mmio_regs, instantiated only under DMEM_MMIO_EN.
REQ-027 RAM array plus write buffer SHALL remain in dmem_responder; no other sub-modules.

Verification
REQ-028 Store 0x1234_5678 to 0x10, load 0x10 the next cycle -> ReadData=0x1234_5678 (forwarded); load 0x10 two cycles later -> same value from RAM.
REQ-029 Stores 0xAAAA_AAAA then 0x5555_5555 to 0x20 on consecutive cycles, load 0x20 afterwards -> 0x5555_5555.
REQ-030 Store to 0x13 (misaligned) and store to 4*DEPTH_WORDS -> both dropped, Err=1 and stays 1; load 4*DEPTH_WORDS -> 0.
REQ-031 Store 0xDEAD_BEEF to 0x40 and assert reset on the following edge -> load 0x40 returns prior RAM value, Err=0, Leds=0.
REQ-032 With DMEM_MMIO_EN: store 0x0000_00FF to 0x8000_0000 -> Leds=0xFF next cycle; two loads of 0x8000_0004 N cycles apart differ by N; store to 0x8000_0004 -> Err=1.
REQ-033 Without DMEM_MMIO_EN: store to 0x8000_0000 -> Err=1, Leds=0, load returns 0.
